// File: rtl/instr_enc_pkg.sv
// Shared encodings for the instruction encoder: class/command codes, fixed funct
// fields, the descriptor struct, and the pack/legality helpers.
package instr_enc_pkg;

   typedef enum logic [1:0] {
      CLS_DP  = 2'b00,
      CLS_MEM = 2'b01,
      CLS_B   = 2'b10,
      CLS_ILL = 2'b11
   } instr_class_e;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [3:0] COND_AL   = 4'b1110;
   localparam logic [5:0] MEM_FUNCT = 6'b011000;
   localparam logic [1:0] B_FUNCT   = 2'b10;

   typedef struct packed {
      logic [1:0]  cls;
      logic [3:0]  cond;
      logic [3:0]  cmd;
      logic        s;
      logic        imm;
      logic        load;
      logic [23:0] opnd;
   } instr_desc_t;

   function automatic logic is_known_cmd(input logic [3:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
             (cmd == CMD_ORR) || (cmd == CMD_CMP);
   endfunction

   function automatic logic is_legal(input instr_desc_t d);
      logic w_ok;
      w_ok = 1'b1;
      if (d.cls == CLS_ILL) begin
         w_ok = 1'b0;
      end else if ((d.cls == CLS_DP) && !is_known_cmd(d.cmd)) begin
         w_ok = 1'b0;
      end
      return w_ok;
   endfunction

   // Anything that is not MEM or B (including the illegal class) uses the DP layout.
   function automatic logic [31:0] pack_word(input instr_desc_t d);
      logic [31:0] w;
      logic        w_s;
      w        = '0;
      w[31:28] = d.cond;
      w[27:26] = d.cls;
      w_s      = d.s | ((d.cls == CLS_DP) && (d.cmd == CMD_CMP));
      case (d.cls)
         CLS_MEM: begin
            w[25:20] = MEM_FUNCT | {5'b00000, d.load};
            w[19:16] = d.opnd[23:20];
            w[15:12] = d.opnd[19:16];
            w[11:0]  = d.opnd[11:0];
         end
         CLS_B: begin
            w[25:24] = B_FUNCT;
            w[23:0]  = d.opnd;
         end
         default: begin
            w[25:20] = {d.imm, d.cmd, w_s};
            w[19:16] = d.opnd[23:20];
            w[15:12] = d.opnd[19:16];
            w[11:0]  = d.opnd[11:0];
         end
      endcase
      return w;
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// DEPTH x WIDTH synchronous FIFO with first-word-fall-through head.
// An empty FIFO presents zero on the head so the write data bus idles at 0.
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
      end
   end

   assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_encoder.sv
// Packs field-level ARM instruction descriptions into 32-bit words and streams them
// into instruction memory. Define INSTR_ENC_CHECK_EN to drop illegal inputs and flag err.
module instr_encoder
   import instr_enc_pkg::*;
#(
   parameter int                DEPTH     = 4,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_class,
   input  logic [3:0]        in_cond,
   input  logic [3:0]        in_cmd,
   input  logic              in_s,
   input  logic              in_imm,
   input  logic              in_load,
   input  logic [23:0]       in_opnd,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [15:0]       wr_count,
   output logic              err
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
   // Input side: in_valid/in_ready; memory side: mem_we (valid) / mem_ready.
   // Producers must hold their payload stable while valid is high and ready is low.

   instr_desc_t       w_desc;
   logic [31:0]       w_word;
   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_count;

   always_comb begin
      w_desc      = '0;
      w_desc.cls  = in_class;
      w_desc.cond = in_cond;
      w_desc.cmd  = in_cmd;
      w_desc.s    = in_s;
      w_desc.imm  = in_imm;
      w_desc.load = in_load;
      w_desc.opnd = in_opnd;
   end

   assign w_word   = pack_word(w_desc);
   assign w_accept = in_valid & in_ready;

`ifdef INSTR_ENC_CHECK_EN
   logic w_legal;
   logic r_err;

   assign w_legal = is_legal(w_desc);
   assign w_push  = w_accept & w_legal;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_accept && !w_legal) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign w_push = w_accept;
   assign err    = 1'b0;
`endif

   instr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_wdata (w_word),
      .i_pop   (w_pop),
      .o_rdata (mem_wdata),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // in_ready ignores a same-cycle pop, so a full FIFO never sees a push.
   assign in_ready = ~w_full;
   assign mem_we   = ~w_empty;
   assign w_pop    = mem_we & mem_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr  <= BASE_ADDR;
         r_count <= '0;
      end else if (w_pop) begin
         r_addr  <= r_addr + ADDR_W'(4);
         r_count <= r_count + 16'd1;
      end
   end

   assign mem_addr = r_addr;
   assign wr_count = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed ARM words checked per scenario.
// Expectations for the illegal-input scenario follow INSTR_ENC_CHECK_EN.
module tb_instr_encoder;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_class;
   logic [3:0]  in_cond;
   logic [3:0]  in_cmd;
   logic        in_s;
   logic        in_imm;
   logic        in_load;
   logic [23:0] in_opnd;
   logic        mem_we;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [15:0] wr_count;
   logic        err;

   int checks;
   int failures;

   instr_encoder #(
      .DEPTH     (4),
      .ADDR_W    (32),
      .BASE_ADDR (32'h0)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_class  (in_class),
      .in_cond   (in_cond),
      .in_cmd    (in_cmd),
      .in_s      (in_s),
      .in_imm    (in_imm),
      .in_load   (in_load),
      .in_opnd   (in_opnd),
      .mem_we    (mem_we),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .wr_count  (wr_count),
      .err       (err)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic set_desc(input logic [1:0] cls, input logic [3:0] cond,
                           input logic [3:0] cmd, input logic s, input logic imm,
                           input logic load, input logic [23:0] opnd);
      in_class = cls;
      in_cond  = cond;
      in_cmd   = cmd;
      in_s     = s;
      in_imm   = imm;
      in_load  = load;
      in_opnd  = opnd;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset     = 1'b1;
      in_valid  = 1'b0;
      mem_ready = 1'b0;
      set_desc(2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 24'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (in_ready !== 1'b1 || mem_we !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags: in_ready=%b mem_we=%b err=%b expected 1 0 0",
                  in_ready, mem_we, err);
      end
      checks++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || wr_count !== 16'd0) begin
         failures++;
         $display("FAIL reset_values: addr=%h wdata=%h count=%0d expected 0 0 0",
                  mem_addr, mem_wdata, wr_count);
      end
   endtask

   task automatic test_add();
      apply_reset();
      mem_ready = 1'b1;
      set_desc(2'b00, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 24'h210005);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'hE2821005) begin
         failures++;
         $display("FAIL add_word: we=%b addr=%h data=%h expected 1 00000000 e2821005",
                  mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk);
      checks++;
      if (wr_count !== 16'd1 || mem_we !== 1'b0 || mem_addr !== 32'h4) begin
         failures++;
         $display("FAIL add_after: count=%0d we=%b addr=%h expected 1 0 00000004",
                  wr_count, mem_we, mem_addr);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      mem_ready = 1'b1;
      set_desc(2'b01, 4'hE, 4'h0, 1'b0, 1'b0, 1'b1, 24'h030008);
      in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'hE5903008) begin
         failures++;
         $display("FAIL ldr_word: we=%b addr=%h data=%h expected 1 00000000 e5903008",
                  mem_we, mem_addr, mem_wdata);
      end
      set_desc(2'b01, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 24'h030008);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'hE5803008) begin
         failures++;
         $display("FAIL str_word: we=%b addr=%h data=%h expected 1 00000004 e5803008",
                  mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0 || wr_count !== 16'd2) begin
         failures++;
         $display("FAIL b2b_count: we=%b count=%0d expected 0 2", mem_we, wr_count);
      end
   endtask

   task automatic test_cmp_branch();
      apply_reset();
      mem_ready = 1'b1;
      set_desc(2'b00, 4'hE, 4'b1010, 1'b0, 1'b1, 1'b0, 24'h100000);
      in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_wdata !== 32'hE3510000) begin
         failures++;
         $display("FAIL cmp_word: we=%b data=%h expected 1 e3510000", mem_we, mem_wdata);
      end
      set_desc(2'b10, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 24'hFFFFFE);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'h0AFFFFFE) begin
         failures++;
         $display("FAIL b_word: we=%b addr=%h data=%h expected 1 00000004 0affffff e",
                  mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_q[$];
      int idx;
      int k;
      logic rdy;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(32'hE2821000 | 32'(i));
      end
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         set_desc(2'b00, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 24'h210000 | 24'(idx));
         in_valid = (idx < 5);
         rdy = in_ready;
         @(posedge clk);
         if (rdy && in_valid) idx++;
      end
      @(negedge clk);
      checks++;
      if (idx !== 4 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_accept: accepted=%0d in_ready=%b expected 4 0", idx, in_ready);
      end
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'hE2821000) begin
         failures++;
         $display("FAIL bp_hold: we=%b addr=%h data=%h expected 1 00000000 e2821000",
                  mem_we, mem_addr, mem_wdata);
      end
      mem_ready = 1'b1;
      k = 0;
      for (int c = 0; c < 20 && k < 5; c++) begin
         if (c != 0) @(negedge clk);
         if (mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL bp_extra: unexpected write data=%h expected none", mem_wdata);
            end else if (mem_wdata !== exp_q[0] || mem_addr !== 32'(4 * k)) begin
               failures++;
               $display("FAIL bp_order: addr=%h data=%h expected %h %h",
                        mem_addr, mem_wdata, 32'(4 * k), exp_q[0]);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            k++;
         end
         set_desc(2'b00, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 24'h210000 | 24'(idx));
         in_valid = (idx < 5);
         rdy = in_ready;
         @(posedge clk);
         if (rdy && in_valid) idx++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (k !== 5) begin
         failures++;
         $display("FAIL bp_timeout: writes=%0d expected 5", k);
      end
      checks++;
      if (wr_count !== 16'd5 || mem_we !== 1'b0 || mem_addr !== 32'h14) begin
         failures++;
         $display("FAIL bp_final: count=%0d we=%b addr=%h expected 5 0 00000014",
                  wr_count, mem_we, mem_addr);
      end
   endtask

   task automatic test_illegal();
      logic [31:0] exp_q[$];
      int k;
      logic exp_err;
      apply_reset();
      mem_ready = 1'b1;
`ifdef INSTR_ENC_CHECK_EN
      exp_q.push_back(32'hE2821005);
      exp_err = 1'b1;
`else
      exp_q.push_back(32'hEC821005);
      exp_q.push_back(32'hE1E21005);
      exp_q.push_back(32'hE2821005);
      exp_err = 1'b0;
`endif
      k = 0;
      for (int c = 0; c < 8; c++) begin
         if (c != 0) @(negedge clk);
         if (mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL ill_extra: unexpected write addr=%h data=%h", mem_addr, mem_wdata);
            end else if (mem_wdata !== exp_q[0] || mem_addr !== 32'(4 * k)) begin
               failures++;
               $display("FAIL ill_word: addr=%h data=%h expected %h %h",
                        mem_addr, mem_wdata, 32'(4 * k), exp_q[0]);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            k++;
         end
         case (c)
            0: set_desc(2'b11, 4'hE, 4'b0100, 1'b0, 1'b0, 1'b0, 24'h210005);
            1: set_desc(2'b00, 4'hE, 4'b1111, 1'b0, 1'b0, 1'b0, 24'h210005);
            2: set_desc(2'b00, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 24'h210005);
            default: set_desc(2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 24'h0);
         endcase
         in_valid = (c < 3);
      end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL ill_missing: %0d words not written", exp_q.size());
      end
      checks++;
      if (err !== exp_err) begin
         failures++;
         $display("FAIL ill_err: err=%b expected %b", err, exp_err);
      end
   endtask

   task automatic test_reset_midstream();
      apply_reset();
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i != 0) @(negedge clk);
         if (i == 2) mem_ready = 1'b0;
         set_desc(2'b00, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 24'h210000 | 24'(i));
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (mem_we !== 1'b1 || wr_count !== 16'd1 || mem_addr !== 32'h4 ||
          mem_wdata !== 32'hE2821001) begin
         failures++;
         $display("FAIL mid_pre: we=%b count=%0d addr=%h data=%h expected 1 1 00000004 e2821001",
                  mem_we, wr_count, mem_addr, mem_wdata);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (mem_we !== 1'b0 || mem_addr !== 32'h0 || wr_count !== 16'd0 ||
          in_ready !== 1'b1 || mem_wdata !== 32'h0) begin
         failures++;
         $display("FAIL mid_reset: we=%b addr=%h count=%0d ready=%b data=%h expected 0 0 0 1 0",
                  mem_we, mem_addr, wr_count, in_ready, mem_wdata);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0 || wr_count !== 16'd0) begin
         failures++;
         $display("FAIL mid_flushed: we=%b count=%0d expected 0 0", mem_we, wr_count);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      mem_ready = 1'b0;
      set_desc(2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 24'h0);
      test_reset();
      test_add();
      test_back_to_back();
      test_cmp_branch();
      test_backpressure();
      test_illegal();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
